// File: rtl/adalight_parse.sv
// rtl/adalight_parse.sv - Adalight frame parser: header hunt, checksum, payload to RAM write port
// Optional idle timeout on partial frames is enabled with `define ADALIGHT_TIMEOUT_EN.
module adalight_parse #(
    parameter int addr_size      = 8,
    parameter int nbyte          = 216,
    parameter int timeout_cycles = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data,
    input  logic                 data_ready,
    output logic [7:0]           data_out,
    output logic [addr_size-1:0] addr,
    output logic                 write_strobe,
    output logic [addr_size-1:0] length,
    output logic                 ready,
    output logic                 error
);

    typedef enum logic [2:0] {
        MAGIC_A,
        MAGIC_D,
        MAGIC_A2,
        CNT_HI,
        CNT_LO,
        CHK,
        PAYLOAD
    } state_t;

    localparam logic [17:0] NBYTE18 = 18'(nbyte);

    state_t                 state_q;
    logic [7:0]             hi_q;
    logic [7:0]             lo_q;
    logic [17:0]            cnt_q;
    logic [17:0]            rem_q;
    logic [7:0]             data_q;
    logic [addr_size-1:0]   addr_q;
    logic [addr_size-1:0]   length_q;
    logic                   strobe_q;
    logic                   ready_q;
    logic                   error_q;

    logic [17:0]            cnt_d;
    logic [17:0]            rem_d;
    logic [17:0]            clip_d;
    logic [7:0]             chk_d;
    logic                   timeout_hit;

    // Count field is LED count minus one; three bytes per LED, max 196608 fits 18 bits.
    assign cnt_d  = cnt_q + 18'd1;
    assign rem_d  = ({2'b00, hi_q, lo_q} + 18'd1) * 18'd3;
    assign clip_d = (rem_q < NBYTE18) ? rem_q : NBYTE18;
    assign chk_d  = hi_q ^ lo_q ^ 8'h55;

`ifdef ADALIGHT_TIMEOUT_EN
    logic [19:0] idle_q;

    // A partial frame is abandoned once the link has been idle for timeout_cycles clocks.
    assign timeout_hit = !data_ready && (state_q != MAGIC_A) &&
                         (idle_q == 20'(timeout_cycles - 1));

    // Idle counter: cleared by every received byte, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else if (data_ready) begin
            idle_q <= '0;
        end else if (idle_q != '1) begin
            idle_q <= idle_q + 20'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Parser FSM; all outputs are registered and strobes are single-cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MAGIC_A;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            length_q <= '0;
            strobe_q <= 1'b0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            if (timeout_hit) begin
                error_q <= 1'b1;
                state_q <= MAGIC_A;
            end else if (data_ready) begin
                case (state_q)
                    MAGIC_A: begin
                        if (data == 8'h41) state_q <= MAGIC_D;
                    end
                    MAGIC_D: begin
                        if (data == 8'h64)      state_q <= MAGIC_A2;
                        else if (data == 8'h41) state_q <= MAGIC_D;
                        else                    state_q <= MAGIC_A;
                    end
                    MAGIC_A2: begin
                        if (data == 8'h61)      state_q <= CNT_HI;
                        else if (data == 8'h41) state_q <= MAGIC_D;
                        else                    state_q <= MAGIC_A;
                    end
                    CNT_HI: begin
                        hi_q    <= data;
                        state_q <= CNT_LO;
                    end
                    CNT_LO: begin
                        lo_q    <= data;
                        state_q <= CHK;
                    end
                    CHK: begin
                        // A bad checksum byte is consumed, not re-examined as a magic byte.
                        if (data == chk_d) begin
                            cnt_q   <= '0;
                            rem_q   <= rem_d;
                            state_q <= PAYLOAD;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= MAGIC_A;
                        end
                    end
                    PAYLOAD: begin
                        // Bytes beyond RAM capacity are consumed but never written.
                        if (cnt_q < NBYTE18) begin
                            data_q   <= data;
                            addr_q   <= cnt_q[addr_size-1:0];
                            strobe_q <= 1'b1;
                        end
                        cnt_q <= cnt_d;
                        if (cnt_d == rem_q) begin
                            length_q <= addr_size'(clip_d - 18'd1);
                            ready_q  <= 1'b1;
                            state_q  <= MAGIC_A;
                        end
                    end
                    default: state_q <= MAGIC_A;
                endcase
            end
        end
    end

    assign data_out     = data_q;
    assign addr         = addr_q;
    assign write_strobe = strobe_q;
    assign length       = length_q;
    assign ready        = ready_q;
    assign error        = error_q;

endmodule

// File: tb/tb_adalight_parse.sv
// tb/tb_adalight_parse.sv - randomized self-checking bench for adalight_parse
module tb_adalight_parse;

`ifdef ADALIGHT_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 1000000;
`endif
    localparam int NBYTE = 216;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic [7:0] addr;
    logic       write_strobe;
    logic [7:0] length;
    logic       ready;
    logic       error;

    adalight_parse #(.addr_size(8), .nbyte(NBYTE), .timeout_cycles(TMO)) dut (
        .clk(clk), .reset(reset), .data(data), .data_ready(data_ready),
        .data_out(data_out), .addr(addr), .write_strobe(write_strobe),
        .length(length), .ready(ready), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    logic [7:0] q_addr[$];
    logic [7:0] q_data[$];
    int rdy_n, err_n, rdy_cyc, err_cyc;
    logic rdy_strobe;
    logic [7:0] rdy_addr;

    always @(negedge clk) begin
        if (!reset) begin
            if (write_strobe) begin
                q_addr.push_back(addr);
                q_data.push_back(data_out);
            end
            if (ready) begin
                rdy_n++;
                rdy_cyc = cyc;
                rdy_strobe = write_strobe;
                rdy_addr = addr;
            end
            if (error) begin
                err_n++;
                err_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        rdy_n = 0;
        err_n = 0;
        rdy_cyc = -1;
        err_cyc = -1;
        rdy_strobe = 1'b0;
        rdy_addr = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        data = b;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        last_cyc = cyc;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_header(input int n_leds, input bit good);
        logic [15:0] c;
        logic [7:0] k;
        c = 16'(n_leds - 1);
        k = c[15:8] ^ c[7:0] ^ 8'h55;
        if (!good) k = k ^ 8'h01;
        send(8'h41, 0);
        send(8'h64, 0);
        send(8'h61, 0);
        send(c[15:8], 0);
        send(c[7:0], 0);
        send(k, 0);
    endtask

    logic [7:0] pl[$];
    logic [7:0] pre[$];
    int exp_len = 0;

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    // Expected result of a good frame: first min(total, NBYTE) payload bytes at
    // addresses 0.., one ready tied to the last byte, length = stored - 1.
    task automatic check_frame(input string nm);
        int total, stored;
        total = pl.size();
        stored = (total < NBYTE) ? total : NBYTE;
        chk({nm, ".strobes"}, q_addr.size(), stored);
        for (int i = 0; i < stored && i < q_addr.size(); i++) begin
            chk({nm, ".addr"}, q_addr[i], i);
            chk({nm, ".data"}, q_data[i], pl[i]);
        end
        chk({nm, ".ready_n"}, rdy_n, 1);
        chk({nm, ".ready_cyc"}, rdy_cyc, last_cyc);
        if (total <= NBYTE) begin
            chk({nm, ".ready_with_strobe"}, rdy_strobe, 1);
            chk({nm, ".ready_addr"}, rdy_addr, stored - 1);
        end
        chk({nm, ".error_n"}, err_n, 0);
        exp_len = stored - 1;
        chk({nm, ".length"}, length, exp_len);
    endtask

    // Sends prefix bytes, a valid header and the payload in pl, then checks.
    task automatic frame(input string nm, input int gap_max, input int stall);
        clear_mon();
        foreach (pre[i]) send(pre[i], 0);
        send_header(pl.size() / 3, 1'b1);
        for (int i = 0; i < pl.size(); i++) begin
            send(pl[i], (i == pl.size() - 1) ? 0 : $urandom_range(0, gap_max));
            if (i == 0) idle(stall);
        end
        idle(3);
        check_frame(nm);
        pre.delete();
    endtask

    initial begin
        clear_mon();
        idle(3);
        chk("rst.write_strobe", write_strobe, 0);
        chk("rst.addr", addr, 0);
        chk("rst.data_out", data_out, 0);
        chk("rst.length", length, 0);
        chk("rst.ready", ready, 0);
        chk("rst.error", error, 0);
        reset = 1'b0;
        idle(2);

        // Two LEDs, fixed payload.
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        frame("led2", 0, 0);

        // Bad checksum: header rejected, payload ignored.
        clear_mon();
        send_header(2, 1'b0);
        chk("badchk.err_cyc_pending", err_n, 0);
        idle(1);
        chk("badchk.err_cyc", err_cyc, last_cyc);
        foreach (pl[i]) send(pl[i], 0);
        idle(3);
        chk("badchk.error_n", err_n, 1);
        chk("badchk.strobes", q_addr.size(), 0);
        chk("badchk.ready_n", rdy_n, 0);
        chk("badchk.length", length, exp_len);

        // Resync through leading garbage and a doubled 'A'.
        pre = '{8'h00, 8'h41};
        pl = '{8'hAA, 8'hBB, 8'hCC};
        frame("resync", 0, 0);

        // Overflow clip: 100 LEDs = 300 bytes into 216-byte RAM.
        fill_random(300);
        frame("overflow", 0, 0);

        // Random frames with random garbage, sizes and inter-byte gaps.
        for (int f = 0; f < 8; f++) begin
            int g;
            g = $urandom_range(0, 4);
            for (int i = 0; i < g; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b == 8'h41) b = 8'h00;
                pre.push_back(b);
            end
            fill_random(3 * $urandom_range(1, 80));
            frame("random", 2, 0);
        end

`ifdef ADALIGHT_TIMEOUT_EN
        // Partial frame abandoned after TMO idle cycles, then a good frame.
        clear_mon();
        send_header(2, 1'b1);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        idle(60);
        chk("timeout.error_n", err_n, 1);
        chk("timeout.error_cyc", err_cyc, last_cyc + TMO);
        chk("timeout.ready_n", rdy_n, 0);
        chk("timeout.length", length, exp_len);
        fill_random(6);
        frame("after_timeout", 0, 0);
`else
        // Without the timeout a stalled frame simply resumes.
        fill_random(6);
        frame("stall", 0, 200);
`endif

        // Reset in the middle of the payload.
        clear_mon();
        send_header(2, 1'b1);
        send(8'h11, 0);
        send(8'h22, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("midrst.write_strobe", write_strobe, 0);
        chk("midrst.addr", addr, 0);
        chk("midrst.data_out", data_out, 0);
        chk("midrst.length", length, 0);
        chk("midrst.ready", ready, 0);
        exp_len = 0;
        clear_mon();
        send(8'h33, 0);
        send(8'h44, 0);
        send(8'h55, 0);
        send(8'h66, 0);
        idle(3);
        chk("midrst.tail_strobes", q_addr.size(), 0);
        chk("midrst.tail_ready", rdy_n, 0);
        fill_random(6);
        frame("after_reset", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adalight_parse.md
Name: adalight_parse

Overview:
- Frame parser between the uart byte receiver and the LED frame RAM. It replaces the raw byte-address receive stage.
- Hunts for the Adalight header ("Ada", count hi, count lo, checksum) and validates it.
- Streams payload bytes into the RAM write port with addresses, then pulses ready so the send/ws2812 path latches a frame.
- Adds framing, resync and overflow clipping to the host link.

Parameters:
- addr_size, 8, width of RAM byte address and of length.
- nbyte, 216, RAM capacity in bytes (nled*3).
- timeout_cycles, 1000000, inter-byte idle clocks before a partial frame is abandoned.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- data  input  8  received byte from uart
- data_ready  input  1  one-cycle strobe, data valid
- data_out  output  8  byte to RAM Data
- addr  output  addr_size  RAM write address
- write_strobe  output  1  RAM WE, one cycle per stored byte
- length  output  addr_size  index of last stored byte of most recent good frame
- ready  output  1  one-cycle pulse, frame complete
- error  output  1  one-cycle pulse, checksum fail or timeout

Behaviour:
- Interface decisions: one clock, clk. Reset is synchronous and active-high on port reset. On reset all outputs are 0 and the state is MAGIC_A.
- States: MAGIC_A, MAGIC_D, MAGIC_A2, CNT_HI, CNT_LO, CHK, PAYLOAD. Transitions occur only on a data_ready cycle, except timeout.
- MAGIC_A: 0x41 goes to MAGIC_D; any other byte stays.
- MAGIC_D: 0x64 goes to MAGIC_A2; 0x41 stays in MAGIC_D; any other byte goes to MAGIC_A.
- MAGIC_A2: 0x61 goes to CNT_HI; 0x41 goes to MAGIC_D; any other byte goes to MAGIC_A.
- CNT_HI, CNT_LO: capture the 16-bit count. The count is LED count minus 1.
- CHK: if the byte equals hi^lo^0x55, go to PAYLOAD, clear the 18-bit byte counter, and set remaining = (count+1)*3 (18 bits, no overflow). On mismatch, pulse error and go to MAGIC_A; the mismatching byte is not re-examined as 'A'.
- PAYLOAD, each data_ready:
  - If byte counter < nbyte: register data_out=data, addr=counter[addr_size-1:0], write_strobe=1 on the next cycle (latency 1).
  - Otherwise the byte is consumed and dropped, with no strobe.
  - The counter increments.
  - When the counter reaches remaining:
    - length = min(remaining, nbyte) - 1.
    - ready pulses in the same cycle as the final write_strobe, or one cycle after the final byte if it was dropped.
    - Return to MAGIC_A.
- data_out and addr hold their last values when write_strobe=0.
- Back-to-back data_ready on consecutive cycles is supported; each byte produces at most one strobe.
- A new frame header is accepted immediately after ready. A byte arriving in the ready cycle is parsed normally.
- length updates only on successful completion. Failed or aborted frames leave length unchanged, but RAM bytes already written stay written.
- Reset asserted mid-frame: synchronous return to MAGIC_A, outputs 0, no ready.

Optional Feature:
- Macro: ADALIGHT_TIMEOUT_EN.
- Defined:
  - A 20-bit idle counter is cleared on every data_ready and increments otherwise.
  - If it reaches timeout_cycles while the state is not MAGIC_A, error pulses once, the state goes to MAGIC_A, and no ready is issued.
  - The counter saturates and takes no action in MAGIC_A.
- Undefined: the counter and its logic are absent; partial frames wait indefinitely.

Test Plan:
- 2-LED frame: bytes 41 64 61 00 01 54 then 11 22 33 44 55 66 -> six strobes with addr 0..5 and data 11..66; ready once, coincident with addr 5; length=5; error never.
- Bad checksum: 41 64 61 00 01 55 then 6 bytes -> error pulses once after the 55; no write_strobe; no ready; length unchanged.
- Resync on noise: 00 41 41 64 61 00 00 55 AA BB CC -> header found despite the leading garbage; three strobes addr 0..2; ready; length=2.
- Overflow clip with nbyte=216: count=0x0063 (100 LEDs, 300 bytes), checksum 0x36 -> exactly 216 strobes (addr 0..215), 84 bytes dropped; ready one cycle after byte 300; length=215.
- Timeout (ADALIGHT_TIMEOUT_EN, timeout_cycles=50): send header for 2 LEDs plus 3 payload bytes, then idle 60 cycles -> error pulses at idle cycle 50, no ready. A following full valid frame completes normally.
- Reset mid-payload after 2 of 6 bytes -> outputs 0 the next cycle. The remaining 4 bytes produce no strobes. A new valid frame then completes normally.
